// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment multiplexed display driver.
package seg7_pkg;

  // Scan FSM: DEAD blanks every anode between digits, SHOW lights one digit.
  typedef enum logic {
    DEAD = 1'b0,
    SHOW = 1'b1
  } state_t;

  // All segments dark on an active-low bus.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low patterns {g,f,e,d,c,b,a} for hex values 0..F.
  localparam logic [6:0] SEG_LUT [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  // Straight table lookup; the table lives in the package so it is shared.
  always_comb begin
    seg_n = SEG_LUT[hex];
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver with dead time between
// digits, a per-frame input snapshot, leading-zero blanking and decimal points.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 1000,
  parameter int DEADTIME    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int MAX_CNT = (REFRESH_DIV > DEADTIME) ? REFRESH_DIV : DEADTIME;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    snap_blank_q, snap_blank_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_above;
  logic [3:0]              sel_hex;
  logic [6:0]              dec_seg;

  // Scan sequencing: dead/show counters, digit index and the frame snapshot.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_blank_d  = snap_blank_q;
    tick_d        = 1'b0;
    case (state_q)
      DEAD: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (idx_q == '0) begin
            snap_digits_d = digits;
            snap_dp_d     = dp_in;
            snap_blank_d  = blank_lz;
            tick_d        = 1'b1;
          end
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = DEAD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = DEAD;
        cnt_d   = '0;
      end
    endcase
  end

  // Blank digit i>0 when blanking is on and it and all higher digits are zero.
  always_comb begin
    zero_above = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above    = zero_above & (snap_digits_d[4*i +: 4] == 4'h0);
      blank_mask[i] = snap_blank_d & zero_above;
    end
  end

  // Decode the digit that will be lit next cycle so outputs carry no extra latency.
  always_comb begin
    sel_hex = snap_digits_d[4*idx_d +: 4];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex   (sel_hex),
    .seg_n (dec_seg)
  );

  // Output pattern for the upcoming state; everything dark unless a visible SHOW slot.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = '1;
    if (state_d == SHOW && !blank_mask[idx_d]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = dec_seg;
      dp_d  = ~snap_dp_d[idx_d];
    end
  end

  // All state and outputs registered; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= DEAD;
      cnt_q         <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blank_q  <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= '1;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blank_q  <= snap_blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      tick_q        <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver with NUM_DIGITS=2, REFRESH_DIV=8, DEADTIME=2.
module tb_seg7_mux_driver;

  localparam logic [6:0] S_OFF = 7'h7F;
  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_A   = 7'b0001000;

  typedef struct packed {
    logic [1:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] digits;
  logic [1:0] dp_in;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       frame_tick;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  seg7_mux_driver #(
    .NUM_DIGITS  (2),
    .REFRESH_DIV (8),
    .DEADTIME    (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h required=%h (an,seg,dp,tick packed low bits)", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [7:0] dig, input logic [1:0] dpi, input logic blk);
    reset    = rst;
    digits   = dig;
    dp_in    = dpi;
    blank_lz = blk;
  endtask

  task automatic pushDark(input int n);
    exp_t e;
    e = '{an: 2'b11, seg: S_OFF, dp: 1'b1, ft: 1'b0};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic pushShow(input logic idx, input logic [6:0] seg_v, input logic dp_req,
                          input logic blanked, input int n, input logic tick);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (blanked) e = '{an: 2'b11, seg: S_OFF, dp: 1'b1, ft: 1'b0};
      else         e = '{an: (idx ? 2'b01 : 2'b10), seg: seg_v, dp: ~dp_req, ft: 1'b0};
      e.ft = tick && (i == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic pushFrame(input logic [6:0] seg0, input logic dp0,
                           input logic [6:0] seg1, input logic dp1, input logic blank1);
    pushShow(1'b0, seg0, dp0, 1'b0, 8, 1'b1);
    pushDark(2);
    pushShow(1'b1, seg1, dp1, blank1, 8, 1'b0);
    pushDark(2);
  endtask

  // Step n cycles, sampling 1 ns after each rising edge and comparing against the queue.
  task automatic runCycles(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_sb_underflow"}, 16'd0, 16'd1);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("%s_c%0d", tag, i), {5'b0, an, seg, dp, frame_tick}, {5'b0, e});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    applyStimulus(1'b0, 8'hFF, 2'b00, 1'b0);
    pushDark(3);
    runCycles("reset", 3);

    applyStimulus(1'b1, 8'h3A, 2'b00, 1'b0);
    pushDark(1);
    pushFrame(S_A, 1'b0, S_3, 1'b0, 1'b0);
    pushFrame(S_A, 1'b0, S_3, 1'b0, 1'b0);
    runCycles("basic", 24);
    applyStimulus(1'b1, 8'h55, 2'b00, 1'b0);
    runCycles("coherent", 17);
    pushFrame(S_5, 1'b0, S_5, 1'b0, 1'b0);
    runCycles("new_snap", 20);

    applyStimulus(1'b1, 8'h05, 2'b00, 1'b1);
    pushFrame(S_5, 1'b0, S_OFF, 1'b0, 1'b1);
    runCycles("blank_on", 20);
    applyStimulus(1'b1, 8'h05, 2'b00, 1'b0);
    pushFrame(S_5, 1'b0, S_0, 1'b0, 1'b0);
    runCycles("blank_off", 20);
    applyStimulus(1'b1, 8'h00, 2'b00, 1'b1);
    pushFrame(S_0, 1'b0, S_OFF, 1'b0, 1'b1);
    runCycles("blank_zero", 20);

    applyStimulus(1'b1, 8'h3A, 2'b10, 1'b0);
    pushFrame(S_A, 1'b0, S_3, 1'b1, 1'b0);
    runCycles("dpoint", 20);

    applyStimulus(1'b1, 8'h3A, 2'b01, 1'b0);
    pushShow(1'b0, S_A, 1'b1, 1'b0, 8, 1'b1);
    pushDark(2);
    pushShow(1'b1, S_3, 1'b0, 1'b0, 3, 1'b0);
    runCycles("pre_rst", 13);
    applyStimulus(1'b0, 8'h3A, 2'b01, 1'b0);
    pushDark(1);
    runCycles("mid_rst", 1);
    applyStimulus(1'b1, 8'h3A, 2'b01, 1'b0);
    pushDark(1);
    pushFrame(S_A, 1'b1, S_3, 1'b0, 1'b0);
    runCycles("restart", 21);

    checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_mux_driver.md
# seg7_mux_driver

Parametrised, time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one active-low segment bus. It snapshots a packed hex-digit vector once per frame and cycles through the digits, with a dead-time gap between digits to prevent ghosting. Optional leading-zero blanking and per-digit decimal points are supported. It sits between the board I/O pins and any logic that produces hex values, such as switch inputs or an adder result.

## Interface
- NUM_DIGITS, 2: digits driven; must be ≥1.
- REFRESH_DIV, 1000: clk cycles each digit is lit; must be ≥1.
- DEADTIME, 16: clk cycles all anodes are off between digits; must be ≥1.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- digits  in  4*NUM_DIGITS  hex values; digit i = digits[4i+3:4i]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high.
- blank_lz  in  1  enables leading-zero blanking.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low; a = bit 0.
- dp  out  1  decimal point, active-low.
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low while lit.
- frame_tick  out  1  one-cycle high pulse when a new frame snapshot is taken.

## Operation
- All outputs are registered.
- Reset values: seg=7'h7F, dp=1, an=all 1s, frame_tick=0, digit index=0, state=DEAD, counter=0, snapshot=0.
- FSM states are DEAD and SHOW.
- **DEAD:** an=all 1s, seg=7'h7F, dp=1. The counter runs 0..DEADTIME-1. At count DEADTIME-1 the FSM moves to SHOW and the counter clears.
- **DEAD→SHOW with index==0:** snapshot ← {digits, dp_in, blank_lz}, and frame_tick=1 for exactly that cycle.
- **SHOW:** an[index]=0 and all other anodes are 1. seg shows the hex decode of snapshot digit[index]. dp = ~snap_dp[index]. The counter runs 0..REFRESH_DIV-1. At count REFRESH_DIV-1 the FSM moves to DEAD and the index advances, wrapping from NUM_DIGITS-1 to 0.
- **Decode (active-low), values 0..F:** 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- **Leading-zero blanking:** applies when snap_blank_lz=1. Digit i>0 is blanked if it and every higher digit are 0. Digit 0 is never blanked.
- A blanked digit keeps an all 1s, seg=7'h7F and dp=1 for its whole SHOW slot. Slot timing is unchanged.
- Inputs change only the snapshot. Mid-frame input changes have no visible effect until the next frame_tick.

## Timing
- Frame period = NUM_DIGITS × (REFRESH_DIV + DEADTIME) cycles.
- After the first rising edge with reset=1, an[0] goes low on the DEADTIME-th edge.
- Output updates coincide with state transitions (registered, no extra latency).
- Reset sampled low at any edge, including mid-SHOW or mid-DEAD: at that edge all outputs return to their reset values and the counter and index clear. Restart is identical to power-up.
- Counter width = $clog2(max(REFRESH_DIV, DEADTIME)). Index width = max(1, $clog2(NUM_DIGITS)).
- With NUM_DIGITS=1 the index stays 0, and frame_tick fires at every DEAD→SHOW transition.

## Structure
- Package seg7_pkg holds:
  - state enum {DEAD, SHOW};
  - SEG_OFF = 7'h7F;
  - a 16-entry constant array of segment patterns.
- Sub-module hex_to_seg7 is combinational: 4-bit in, 7-bit active-low out. It is instantiated once on the selected snapshot digit.
- Blanking mask generation and the FSM/counters stay in the top.

## Test plan
All scenarios use NUM_DIGITS=2, REFRESH_DIV=8, DEADTIME=2.
- **Reset:** hold reset=0 for 3 cycles with digits=8'hFF → seg=7F, dp=1, an=11, frame_tick=0 every cycle.
- **Basic cycling:** digits=8'h3A, blank_lz=0, release reset → the following sequence repeats with a 20-cycle period, and frame_tick pulses once per period:
  - 2 cycles an=11;
  - 8 cycles an=10, seg=0001000;
  - 2 cycles an=11;
  - 8 cycles an=01, seg=0110000.
- **Snapshot coherence:** change digits from 8'h3A to 8'h55 during the digit-0 slot → the digit-1 slot still shows 3 (0110000). Both digits show 5 (0010010) only after the next frame_tick.
- **Leading-zero blanking:** digits=8'h05, blank_lz=1 → the digit-1 slot keeps an=11, seg=7F. With blank_lz=0 it shows seg=1000000. With digits=8'h00, blank_lz=1 → digit 0 shows 1000000.
- **Decimal point:** dp_in=2'b10 → dp=0 only during the an=01 slot, and dp=1 at all other times.
- **Reset mid-operation:** assert reset during an=01 → the next edge gives an=11, seg=7F. After release, an[0] goes low on the 2nd edge, with frame_tick=1 on that cycle.
